adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans three analog channels through a shared A/D converter.
// Each sample is captured into R0..R2. After the third capture the controller
// presents the smallest sample and its channel index to a consumer, using a
// dav_/rfd four-phase handshake.
// Optional feature macro ADC_SCAN_TIMEOUT_EN: bounds every EOC wait to
// TIMEOUT_CYCLES. On expiry the sample is forced to 0xFF and a sticky err is set.
module adc_scan_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x,
    output logic [1:0] sel,
    output logic [7:0] min,
    output logic [1:0] chan,
    output logic       dav_,
    input  logic       rfd
`ifdef ADC_SCAN_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [2:0] {
        START,
        WAIT_LO,
        WAIT_HI,
        LOAD,
        PRESENT,
        ACK
    } state_t;

    // Reject an out-of-range wait limit when the design is elaborated.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("adc_scan_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state_q, state_d;
    logic       soc_q, soc_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] min_q, min_d;
    logic [1:0] chan_q, chan_d;
    logic       dav_q, dav_d;
    logic [7:0] r_q [3];
    logic [7:0] r_d [3];

    logic       capture;
    logic [7:0] cap_val;
    logic [7:0] lo_val;
    logic [1:0] lo_idx;

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = TIMEOUT_CYCLES[7:0];
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // Smallest of the three registered samples; strict compare keeps the lowest index on ties.
    always_comb begin
        lo_val = r_q[0];
        lo_idx = 2'd0;
        if (r_q[1] < lo_val) begin
            lo_val = r_q[1];
            lo_idx = 2'd1;
        end
        if (r_q[2] < lo_val) begin
            lo_val = r_q[2];
            lo_idx = 2'd2;
        end
    end

    // Next-state and registered-output logic of the scan/handshake controller.
    always_comb begin
        state_d = state_q;
        soc_d   = soc_q;
        sel_d   = sel_q;
        min_d   = min_q;
        chan_d  = chan_q;
        dav_d   = dav_q;
        r_d     = r_q;
        capture = 1'b0;
        cap_val = x;
`ifdef ADC_SCAN_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            START: begin
                soc_d   = 1'b1;
                state_d = WAIT_LO;
`ifdef ADC_SCAN_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_LO: begin
                if (!eoc) begin
                    soc_d   = 1'b0;
                    state_d = WAIT_HI;
`ifdef ADC_SCAN_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
`ifdef ADC_SCAN_TIMEOUT_EN
                else if (cnt_q == TMO_LIMIT) begin
                    capture = 1'b1;
                    cap_val = 8'hFF;
                    soc_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            WAIT_HI: begin
                if (eoc) begin
                    capture = 1'b1;
                end
`ifdef ADC_SCAN_TIMEOUT_EN
                else if (cnt_q == TMO_LIMIT) begin
                    capture = 1'b1;
                    cap_val = 8'hFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            LOAD: begin
                min_d   = lo_val;
                chan_d  = lo_idx;
                dav_d   = 1'b0;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (rfd) begin
                    dav_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!rfd) begin
                    sel_d   = 2'd0;
                    state_d = START;
                end
            end
            default: state_d = START;
        endcase

        // Real and timed-out captures share one path so the scan continues identically.
        if (capture) begin
            r_d[sel_q] = cap_val;
            if (sel_q < 2'd2) begin
                sel_d   = sel_q + 2'd1;
                state_d = START;
            end else begin
                state_d = LOAD;
            end
        end
    end

    // State and output registers; synchronous reset overrides every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= START;
            soc_q   <= 1'b0;
            sel_q   <= 2'd0;
            min_q   <= '0;
            chan_q  <= 2'd0;
            dav_q   <= 1'b1;
            r_q     <= '{default: '0};
`ifdef ADC_SCAN_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            sel_q   <= sel_d;
            min_q   <= min_d;
            chan_q  <= chan_d;
            dav_q   <= dav_d;
            r_q     <= r_d;
`ifdef ADC_SCAN_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign soc  = soc_q;
    assign sel  = sel_q;
    assign min  = min_q;
    assign chan = chan_q;
    assign dav_ = dav_q;
`ifdef ADC_SCAN_TIMEOUT_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: a converter model answers soc pulses with
// per-channel samples. Expected min/chan pairs go into a queue, and a monitor
// compares them each time dav_ falls.
module tb_adc_scan_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rfd   = 1'b0;
    logic       eoc;
    logic [7:0] x;
    logic       soc;
    logic [1:0] sel;
    logic [7:0] min;
    logic [1:0] chan;
    logic       dav_;
`ifdef ADC_SCAN_TIMEOUT_EN
    logic       err;
`endif

    adc_scan_ctrl #(.TIMEOUT_CYCLES(10)) dut (
        .clock (clock),
        .reset (reset),
        .soc   (soc),
        .eoc   (eoc),
        .x     (x),
        .sel   (sel),
        .min   (min),
        .chan  (chan),
        .dav_  (dav_),
        .rfd   (rfd)
`ifdef ADC_SCAN_TIMEOUT_EN
        ,
        .err   (err)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] m;
        logic [1:0] c;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sel_log[$];
    logic [7:0] samp [3];
    logic       model_off = 1'b0;
    logic       stuck_ch1 = 1'b0;
    int         cyc       = 0;
    int         rise_cyc  = 0;
    int         n_vec     = 0;
    int         n_bad     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Converter model: on soc it drops eoc, then 3 cycles later raises it with samp[sel].
    initial begin : conv_model
        int  mcnt;
        bit  busy;
        mcnt = 0;
        busy = 0;
        eoc  = 1'b1;
        x    = 8'h00;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                eoc  = 1'b1;
                busy = 0;
            end else if (busy) begin
                mcnt++;
                if (mcnt == 3) begin
                    x        = samp[sel];
                    eoc      = 1'b1;
                    busy     = 0;
                    rise_cyc = cyc;
                    sel_log.push_back(sel);
                end
            end else if (soc && eoc && !model_off && !(stuck_ch1 && sel == 2'd1)) begin
                eoc  = 1'b0;
                mcnt = 0;
                busy = 1;
            end
        end
    end

    // Monitor: checks each dav_ fall against the scoreboard, then checks min/chan stay stable while dav_ is low.
    initial begin : monitor
        logic       prev;
        logic [7:0] hmin;
        logic [1:0] hchan;
        exp_t       e;
        prev  = 1'b1;
        hmin  = '0;
        hchan = '0;
        forever begin
            @(negedge clock);
            if (!reset && dav_ === 1'b0) begin
                if (prev === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_dav", {31'd0, dav_}, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("min", {24'd0, min}, {24'd0, e.m});
                        check("chan", {30'd0, chan}, {30'd0, e.c});
                        check("eoc_to_dav_latency", cyc - rise_cyc, 32'd2);
                    end
                    hmin  = min;
                    hchan = chan;
                end else begin
                    check("present_hold", {22'd0, min, chan}, {22'd0, hmin, hchan});
                end
            end
            prev = dav_;
        end
    end

    task automatic wait_dav(input int limit);
        int k;
        k = 0;
        while (dav_ !== 1'b0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        if (dav_ !== 1'b0) check("dav_timeout", {31'd0, dav_}, 32'd0);
    endtask

    task automatic scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] em, input logic [1:0] ec, input bit poke);
        bit ok;
        samp[0] = a;
        samp[1] = b;
        samp[2] = c;
        exp_q.push_back(exp_t'({em, ec}));
        sel_log.delete();
        if (poke) begin
            @(posedge clock); #1 rfd = 1'b1;
            repeat (3) @(posedge clock);
            #1 rfd = 1'b0;
        end
        wait_dav(150);
        ok = (sel_log.size() == 3);
        if (ok) ok = (sel_log[0] == 2'd0) && (sel_log[1] == 2'd1) && (sel_log[2] == 2'd2);
        check("sel_sequence_0_1_2", {31'd0, ok}, 32'd1);
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clock);
        check("dav_held_low", {31'd0, dav_}, 32'd0);
        @(posedge clock); #1 rfd = 1'b1;
        @(posedge clock); @(negedge clock);
        check("dav_rise_after_rfd", {31'd0, dav_}, 32'd1);
        @(posedge clock); #1 rfd = 1'b0;
        @(posedge clock); @(posedge clock); @(negedge clock);
        check("restart_soc_sel", {30'd0, soc, sel}, {30'd0, 1'b1, 2'd0});
    endtask

    initial begin : stimulus
        int  k;
        bit  ok;
        samp[0] = 8'h40;
        samp[1] = 8'h10;
        samp[2] = 8'h80;
        reset   = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", {20'd0, soc, sel, min, chan, dav_}, {20'd0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1});
`ifdef ADC_SCAN_TIMEOUT_EN
        check("reset_err", {31'd0, err}, 32'd0);
`endif
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); @(negedge clock);
        check("first_soc_after_reset", {31'd0, soc}, 32'd1);

        scan(8'h40, 8'h10, 8'h80, 8'h10, 2'd1, 1'b0);
        handshake(20);
        scan(8'h22, 8'h22, 8'h22, 8'h22, 2'd0, 1'b1);
        handshake(2);
        scan(8'hFF, 8'hFF, 8'h00, 8'h00, 2'd2, 1'b0);
        handshake(1);
        scan(8'h00, 8'h00, 8'h05, 8'h00, 2'd0, 1'b0);
        handshake(0);
        scan(8'h07, 8'h03, 8'h03, 8'h03, 2'd1, 1'b0);
        handshake(1);
        scan(8'h90, 8'h91, 8'h90, 8'h90, 2'd0, 1'b0);
        handshake(1);

        // Abort a scan with reset while channel 1 is converting (WAIT_HI, sel=1).
        samp[0] = 8'h11;
        samp[1] = 8'h22;
        samp[2] = 8'h33;
        k = 0;
        while (!(sel == 2'd1 && soc == 1'b0 && eoc == 1'b0) && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("reach_wait_hi_sel1", {31'd0, (k < 100)}, 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("mid_scan_reset", {20'd0, soc, sel, dav_, min}, {20'd0, 1'b0, 2'd0, 1'b1, 8'h00});
        @(posedge clock); #1 reset = 1'b0;
        scan(8'h55, 8'h66, 8'h44, 8'h44, 2'd2, 1'b0);
        handshake(1);

`ifdef ADC_SCAN_TIMEOUT_EN
        // Channel 1 never answers: its sample times out to 0xFF and err latches.
        @(posedge clock); #1 reset = 1'b1;
        stuck_ch1 = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        samp[0] = 8'h30;
        samp[1] = 8'h00;
        samp[2] = 8'h50;
        exp_q.push_back(exp_t'({8'h30, 2'd0}));
        wait_dav(300);
        check("timeout_err", {31'd0, err}, 32'd1);
        handshake(1);
        check("err_sticky", {31'd0, err}, 32'd1);
        stuck_ch1 = 1'b0;
`else
        // eoc never falls: the controller must wait in WAIT_LO indefinitely.
        @(posedge clock); #1 reset = 1'b1;
        model_off = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (!(soc === 1'b1 && dav_ === 1'b1 && sel === 2'd0)) ok = 1'b0;
        end
        check("eoc_stuck_wait", {31'd0, ok}, 32'd1);
        model_off = 1'b0;
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
